ofm_buffer_reader: RTL
======================

Name: ofm_buffer_reader

Overview:
- Read-side sequencer for the 64-bit output-feature-map buffer.
- Drives the buffer's read address port and captures the returned 64-bit bundles.
- Streams the bundles downstream (toward the DDR writeback / next-layer loader) over a valid/ready interface with m_last framing.
- Handles the buffer's fixed 1-cycle read latency under arbitrary backpressure, with no word lost or duplicated.

Parameters:
- DEPTH, 114*114: number of buffer words; addresses wrap from DEPTH-1 to 0.
- ADDR_BIT, 14: width of the buffer address.
- WIDTH, 64: bundle width in bits.
- LEN_BIT, 15: width of the transfer length count.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  input  ADDR_BIT  first buffer address; latched on accepted start.
- num_words  input  LEN_BIT  words to read; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the transfer completes.
- bram_read_addr  output  ADDR_BIT  buffer read address (registered).
- bram_rd_data  input  WIDTH  buffer read data; valid 1 cycle after the address is presented; the buffer port has no read enable.
- m_data  output  WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from the consumer.
- m_last  output  1  high with the final word of the transfer.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, bram_read_addr=0; internal FIFO empty; in-flight flag cleared; state IDLE.
- State machine: IDLE, RUN, DRAIN.
  - IDLE: start=1 with num_words>0 latches base_addr and num_words and moves to RUN; busy=1 next cycle.
  - IDLE: start=1 with num_words=0 moves no state; done pulses next cycle; busy stays 0; no beats.
  - RUN: issues reads. Once the last address is issued, moves to DRAIN.
  - DRAIN: no reads issued. When the final beat handshakes (m_valid & m_ready & m_last), done=1 for one cycle, busy=0 that same cycle, state returns to IDLE.
  - start is ignored while busy.
- Read issue:
  - Internal 4-entry FIFO holds returned words.
  - A read is issued in a cycle only if fifo_count + inflight < 4. Pops in the same cycle are not credited (conservative).
  - An issue registers bram_read_addr=next address and sets inflight for the following cycle.
  - In that following cycle bram_rd_data is pushed into the FIFO.
  - When no read is issued, bram_read_addr holds its value and no push occurs.
- Address arithmetic:
  - Next address = address+1.
  - When address = DEPTH-1, next address = 0 (wrap).
  - The issued-word counter counts down from num_words; RUN ends when it reaches 0.
- Stream output:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - Pop on m_valid & m_ready.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
  - m_last is asserted on the num_words-th beat only; a separate delivered-word counter generates it.
- Latency and throughput:
  - Start accepted at edge T; first address presented in cycle T+1.
  - Data captured at the end of T+2; first m_valid in cycle T+3.
  - With m_ready held high: 1 word/cycle sustained; done at cycle T+3+num_words.
- Simultaneous push and pop in one cycle: FIFO count unchanged; data order preserved.
- FIFO overflow and underflow are impossible by construction. Verify by assertion: count never exceeds 4.
- rst asserted mid-transfer: next cycle returns everything to reset values, discards in-flight data, no done pulse. A bram_rd_data arriving one cycle after rst is ignored.

Test Plan:
- Basic transfer: base_addr=100, num_words=8, m_ready=1, buffer word k = k → m_data 100..107 on consecutive cycles T+3..T+10; m_last on 107; done at T+11; bram_read_addr 100..107.
- Backpressure: num_words=16, m_ready toggled 1,0,0,1,0 pattern → exactly 16 beats, in order, no duplicates; data stable while stalled; FIFO count ≤4 throughout.
- Wrap: DEPTH=12996, base_addr=12994, num_words=4 → addresses 12994, 12995, 0, 1; data in that order; m_last on address 1's word.
- Zero length: start with num_words=0 → done pulse at T+1; busy stays 0; m_valid never high.
- Reset mid-run: rst after 3 of 10 beats, then a new start with base_addr=0, num_words=2 → outputs at reset values for one cycle; only the 2 new words stream; no stale word appears.
- Start while busy: second start during RUN with a different base_addr → ignored; original transfer completes unchanged with a single done pulse.

Source files
------------

// File: rtl/ofm_buffer_reader.sv
// Read-side sequencer for the output-feature-map buffer: issues buffer reads,
// absorbs the two-stage read pipeline in a small FIFO and streams words with last framing.
module ofm_buffer_reader #(
    parameter int unsigned DEPTH    = 114 * 114,
    parameter int unsigned ADDR_BIT = 14,
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned LEN_BIT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_BIT-1:0] base_addr,
    input  logic [LEN_BIT-1:0]  num_words,
    output logic                busy,
    output logic                done,
    output logic [ADDR_BIT-1:0] bram_read_addr,
    input  logic [WIDTH-1:0]    bram_rd_data,
    output logic [WIDTH-1:0]    m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last
);

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_BIT    = 2;
    localparam int unsigned CNT_BIT    = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_BIT-1:0]   r_addr, w_addr_nxt;
    logic [LEN_BIT-1:0]    r_issue_left, w_issue_left_nxt;
    logic [LEN_BIT-1:0]    r_deliver_left, w_deliver_left_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic [ADDR_BIT-1:0]   r_bram_addr;
    logic [1:0]            r_pend;
    logic [WIDTH-1:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_BIT-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
    logic [CNT_BIT-1:0]    r_count, w_count_nxt, w_count_after_pop;
    logic                  r_m_valid, r_m_last, w_m_last_nxt;
    logic [WIDTH-1:0]      r_m_data, w_head_nxt;
    logic                  w_pop, w_push, w_issue;
    logic [CNT_BIT-1:0]    w_inflight;
    logic [ADDR_BIT-1:0]   w_addr_inc;

    // Pipeline bookkeeping: r_pend[0] = address on the bus, r_pend[1] = data on the bus.
    always_comb begin
        w_pop             = r_m_valid & m_ready;
        w_push            = r_pend[1];
        w_inflight        = CNT_BIT'(r_pend[0]) + CNT_BIT'(r_pend[1]);
        w_issue           = (r_state == S_RUN) && ((r_count + w_inflight) < CNT_BIT'(FIFO_DEPTH));
        w_addr_inc        = (r_addr == ADDR_BIT'(DEPTH - 1)) ? '0 : r_addr + ADDR_BIT'(1);
        w_count_after_pop = r_count - CNT_BIT'(w_pop);
        w_count_nxt       = w_count_after_pop + CNT_BIT'(w_push);
        w_rd_ptr_nxt      = r_rd_ptr + PTR_BIT'(w_pop);
        // An empty FIFO receiving a push exposes the incoming word directly as the new head.
        w_head_nxt        = (w_push && (w_count_after_pop == '0)) ? bram_rd_data : r_fifo[w_rd_ptr_nxt];
    end

    // Next-state and control-register logic.
    always_comb begin
        w_state_nxt        = r_state;
        w_addr_nxt         = r_addr;
        w_issue_left_nxt   = r_issue_left;
        w_deliver_left_nxt = r_deliver_left - LEN_BIT'(w_pop);
        w_busy_nxt         = r_busy;
        w_done_nxt         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        w_state_nxt        = S_RUN;
                        w_addr_nxt         = base_addr;
                        w_issue_left_nxt   = num_words;
                        w_deliver_left_nxt = num_words;
                        w_busy_nxt         = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_issue) begin
                    w_addr_nxt       = w_addr_inc;
                    w_issue_left_nxt = r_issue_left - LEN_BIT'(1);
                    if (r_issue_left == LEN_BIT'(1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && r_m_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_m_last_nxt = (w_count_nxt != '0) && (w_deliver_left_nxt == LEN_BIT'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_issue_left   <= '0;
            r_deliver_left <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_bram_addr    <= '0;
            r_pend         <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_m_valid      <= 1'b0;
            r_m_data       <= '0;
            r_m_last       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_addr         <= w_addr_nxt;
            r_issue_left   <= w_issue_left_nxt;
            r_deliver_left <= w_deliver_left_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            if (w_issue) begin
                r_bram_addr <= r_addr;
            end
            r_pend         <= {r_pend[0], w_issue};
            r_wr_ptr       <= r_wr_ptr + PTR_BIT'(w_push);
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_m_valid      <= (w_count_nxt != '0);
            r_m_data       <= w_head_nxt;
            r_m_last       <= w_m_last_nxt;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo[r_wr_ptr] <= bram_rd_data;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign bram_read_addr = r_bram_addr;
    assign m_data         = r_m_data;
    assign m_valid        = r_m_valid;
    assign m_last         = r_m_last;

    a_fifo_bound: assert property (@(posedge clk) disable iff (rst) r_count <= CNT_BIT'(FIFO_DEPTH));

endmodule
